fastram_bridge: RTL and testbench

- Sits directly downstream of the core/top fastram port (23-bit address, 8-bit data, we, ce) and upstream of the SDRAM controller.
- Turns the core's per-phase combinational accesses into a req/ack SDRAM handshake.
- Posts writes into a small FIFO so CPU writes do not stall.
- Holds read data stable for the core and asserts cpu_wait while a read is in flight.

---
 rtl/fastram_pkg.sv | 27 ++
 rtl/fastram_wfifo.sv | 81 ++++++++
 rtl/fastram_bridge.sv | 174 +++++++++++++++++
 tb/tb_fastram_bridge.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fastram_pkg.sv
// ============================================================================
// Module : fastram_pkg
// Brief  : Shared types for the fastram-to-SDRAM bridge.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fastram_pkg;

  localparam int c_aw_default = 23;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_ISSUE = 2'd1,
    ST_RD_ISSUE = 2'd2,
    ST_RD_WAIT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [c_aw_default-1:0] addr;
    logic [7:0]              data;
  } wentry_t;

endpackage

`default_nettype wire

// File: rtl/fastram_wfifo.sv
// ============================================================================
// Module : fastram_wfifo
// Brief  : Posted-write FIFO; youngest-match lookup port exists only when
//          FASTRAM_FWD_EN is defined.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fastram_wfifo
  import fastram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = c_aw_default
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [AW+7:0] i_din,
  input  logic          i_pop,
  output logic [AW+7:0] o_dout,
  output logic          o_full,
  output logic          o_empty
`ifdef FASTRAM_FWD_EN
  ,
  input  logic [AW-1:0] i_lk_addr,
  output logic          o_lk_hit,
  output logic [7:0]    o_lk_data
`endif
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  logic [AW+7:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + PW'(1);
      if (i_pop)  r_rp <= r_rp + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp[IW-1:0]] <= i_din;
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[PW-1] != r_rp[PW-1]) && (r_wp[IW-1:0] == r_rp[IW-1:0]);
  assign o_dout  = r_mem[r_rp[IW-1:0]];

`ifdef FASTRAM_FWD_EN
  logic [PW-1:0] w_cnt;
  logic [IW-1:0] w_idx;

  assign w_cnt = r_wp - r_rp;

  // Scan oldest to youngest so the last hit wins.
  always_comb begin
    o_lk_hit  = 1'b0;
    o_lk_data = 8'h00;
    w_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rp[IW-1:0] + IW'(i);
      if ((PW'(i) < w_cnt) && (r_mem[w_idx][AW+7:8] == i_lk_addr)) begin
        o_lk_hit  = 1'b1;
        o_lk_data = r_mem[w_idx][7:0];
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/fastram_bridge.sv
// ============================================================================
// Module : fastram_bridge
// Brief  : Core fastram port to SDRAM req/ack bridge with posted writes.
//          Define FASTRAM_FWD_EN to forward reads from pending writes.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fastram_bridge
  import fastram_pkg::*;
#(
  parameter int AW          = c_aw_default,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          phase_strobe,
  input  logic          cpu_ce,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_wait,
  output logic          sdram_req,
  output logic          sdram_we,
  output logic [AW-1:0] sdram_addr,
  output logic [7:0]    sdram_wdata,
  input  logic          sdram_ack,
  input  logic          sdram_rvalid,
  input  logic [7:0]    sdram_rdata
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_wait;
  logic          r_rd_pend;
  logic          r_hold_v;
  logic [7:0]    r_rdata;
  logic [AW-1:0] r_rd_addr;
  logic [AW+7:0] r_hold;

  logic          w_acc;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_can_push;
  logic          w_push;
  logic [AW+7:0] w_din;
  logic [AW+7:0] w_head;
  logic          w_fwd_hit;
  logic [7:0]    w_fwd_data;

  assign w_acc      = phase_strobe & cpu_ce & ~r_wait;
  assign w_pop      = (r_state == ST_WR_ISSUE) & sdram_ack;
  // A pop on the same edge makes room even when the FIFO reads full.
  assign w_can_push = ~w_full | w_pop;
  assign w_push     = r_hold_v ? w_can_push : (w_acc & cpu_we & w_can_push);
  assign w_din      = r_hold_v ? r_hold : {cpu_addr, cpu_wdata};

`ifdef FASTRAM_FWD_EN
  logic       w_lk_hit;
  logic [7:0] w_lk_data;
  logic       w_hold_hit;

  assign w_hold_hit = r_hold_v && (r_hold[AW+7:8] == cpu_addr);
  assign w_fwd_hit  = w_hold_hit | w_lk_hit;
  assign w_fwd_data = w_hold_hit ? r_hold[7:0] : w_lk_data;
`else
  assign w_fwd_hit  = 1'b0;
  assign w_fwd_data = 8'h00;
`endif

  fastram_wfifo #(
    .DEPTH (WFIFO_DEPTH),
    .AW    (AW)
  ) u_wfifo (
    .clk       (clk_sys),
    .rst       (reset),
    .i_push    (w_push),
    .i_din     (w_din),
    .i_pop     (w_pop),
    .o_dout    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
`ifdef FASTRAM_FWD_EN
    ,
    .i_lk_addr (cpu_addr),
    .o_lk_hit  (w_lk_hit),
    .o_lk_data (w_lk_data)
`endif
  );

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Reads only issue from an empty FIFO, so they never pass older writes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty)       w_state_nxt = ST_WR_ISSUE;
        else if (r_rd_pend) w_state_nxt = ST_RD_ISSUE;
      end
      ST_WR_ISSUE: if (sdram_ack)    w_state_nxt = ST_IDLE;
      ST_RD_ISSUE: if (sdram_ack)    w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  if (sdram_rvalid) w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sdram_req   = 1'b0;
    sdram_we    = 1'b0;
    sdram_addr  = '0;
    sdram_wdata = 8'h00;
    case (r_state)
      ST_WR_ISSUE: begin
        sdram_req   = 1'b1;
        sdram_we    = 1'b1;
        sdram_addr  = w_head[AW+7:8];
        sdram_wdata = w_head[7:0];
      end
      ST_RD_ISSUE: begin
        sdram_req  = 1'b1;
        sdram_addr = r_rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wait    <= 1'b0;
      r_rd_pend <= 1'b0;
      r_hold_v  <= 1'b0;
      r_rdata   <= 8'h00;
      r_rd_addr <= '0;
      r_hold    <= '0;
    end else begin
      if (r_hold_v && w_can_push) begin
        r_hold_v <= 1'b0;
        r_wait   <= 1'b0;
      end
      if (w_acc && cpu_we && !w_can_push) begin
        r_hold_v <= 1'b1;
        r_hold   <= {cpu_addr, cpu_wdata};
        r_wait   <= 1'b1;
      end
      if (w_acc && !cpu_we) begin
        if (w_fwd_hit) begin
          r_rdata <= w_fwd_data;
        end else begin
          r_rd_pend <= 1'b1;
          r_rd_addr <= cpu_addr;
          r_wait    <= 1'b1;
        end
      end
      if ((r_state == ST_RD_WAIT) && sdram_rvalid) begin
        r_rdata   <= sdram_rdata;
        r_wait    <= 1'b0;
        r_rd_pend <= 1'b0;
      end
    end
  end

  assign cpu_wait  = r_wait;
  assign cpu_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_fastram_bridge.sv
// ============================================================================
// Module : tb_fastram_bridge
// Brief  : Randomized self-checking bench for fastram_bridge against a
//          transaction-level model of the CPU and SDRAM sides.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fastram_bridge;
  import fastram_pkg::*;

  localparam int AW    = 23;
  localparam int DEPTH = 4;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          phase_strobe = 1'b0;
  logic          cpu_ce = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = 8'h00;
  logic [7:0]    cpu_rdata;
  logic          cpu_wait;
  logic          sdram_req;
  logic          sdram_we;
  logic [AW-1:0] sdram_addr;
  logic [7:0]    sdram_wdata;
  logic          sdram_ack = 1'b0;
  logic          sdram_rvalid = 1'b0;
  logic [7:0]    sdram_rdata = 8'h00;

  always #5 clk_sys = ~clk_sys;

  fastram_bridge #(.AW(AW), .WFIFO_DEPTH(DEPTH)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .phase_strobe (phase_strobe),
    .cpu_ce       (cpu_ce),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_wait     (cpu_wait),
    .sdram_req    (sdram_req),
    .sdram_we     (sdram_we),
    .sdram_addr   (sdram_addr),
    .sdram_wdata  (sdram_wdata),
    .sdram_ack    (sdram_ack),
    .sdram_rvalid (sdram_rvalid),
    .sdram_rdata  (sdram_rdata)
  );

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } tx_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // CPU-visible model: program-order memory, posted writes, expected SDRAM order.
  logic [7:0]    golden [logic [AW-1:0]];
  logic [7:0]    sdmem  [logic [AW-1:0]];
  wentry_t       wq[$];
  tx_t           exp_tx[$];
  bit            m_wait, m_hold, m_rd_pend, m_rd_acked;
  logic [7:0]    m_rdata, m_rd_exp;
  logic [AW-1:0] m_rd_addr;

  int            ack_delay = 0, req_cycles = 0, rv_delay = 1, rv_wait = 0;
  bit            rv_on = 0, rand_ack = 0, stray_en = 0, force_rv = 0;
  bit            prev_pend = 0, prev_rst = 1;
  logic          prev_we;
  logic [AW-1:0] prev_addr;
  logic [7:0]    prev_wd;
  logic [AW-1:0] last_addr;
  logic [7:0]    last_wd;
  int            n_wr_acks = 0;

  function automatic logic [7:0] dflt(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] golden_get(input logic [AW-1:0] a);
    return golden.exists(a) ? golden[a] : dflt(a);
  endfunction

  function automatic logic [7:0] sd_get(input logic [AW-1:0] a);
    return sdmem.exists(a) ? sdmem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit rst, input bit ps, input bit ce, input bit we,
                      input logic [AW-1:0] a, input logic [7:0] d);
    bit         ack, rv, wr_ack, rd_ack, acc, old_hold, old_acked, hit, nwait;
    logic [7:0] rvd;
    tx_t        t;
    @(negedge clk_sys);
    if (prev_pend && !prev_rst)
      chk("req_held", {sdram_req, sdram_we, sdram_addr, sdram_wdata},
          {1'b1, prev_we, prev_addr, prev_wd});
    if (exp_tx.size() == 0) chk("idle_req", sdram_req, 0);

    rv = 0; rvd = 8'h00;
    if (!rst && rv_on) begin
      rv_wait--;
      if (rv_wait == 0) begin rv = 1; rvd = sd_get(m_rd_addr); rv_on = 0; end
    end else if (!m_rd_acked && (force_rv || (stray_en && ($urandom % 8 == 0)))) begin
      rv = 1; rvd = 8'($urandom);
    end

    ack = 0;
    if (!rst && sdram_req) begin
      if (req_cycles >= ack_delay) ack = 1;
      else req_cycles++;
    end

    reset = rst; phase_strobe = ps; cpu_ce = ce; cpu_we = we;
    cpu_addr = a; cpu_wdata = d;
    sdram_ack = ack; sdram_rvalid = rv; sdram_rdata = rvd;

    prev_pend = sdram_req && !ack; prev_rst = rst;
    prev_we = sdram_we; prev_addr = sdram_addr; prev_wd = sdram_wdata;

    wr_ack = 0; rd_ack = 0;
    if (ack && exp_tx.size() != 0) begin
      t = exp_tx.pop_front();
      chk("tx_we", sdram_we, t.we);
      chk("tx_addr", sdram_addr, t.addr);
      if (t.we) begin
        chk("tx_wdata", sdram_wdata, t.data);
        sdmem[t.addr] = t.data;
        wr_ack = 1; n_wr_acks++;
        last_addr = sdram_addr; last_wd = sdram_wdata;
      end else rd_ack = 1;
      req_cycles = 0;
      if (rand_ack) ack_delay = $urandom_range(0, 6);
    end

    acc = !rst && ps && ce && !m_wait;
    old_hold = m_hold; old_acked = m_rd_acked;
    if (rst) begin
      wq.delete(); exp_tx.delete();
      m_wait = 0; m_hold = 0; m_rd_pend = 0; m_rd_acked = 0; m_rdata = 8'h00;
      rv_on = 0; req_cycles = 0;
      golden = sdmem;
    end else begin
      nwait = m_wait;
      if (acc && !we) begin
        hit = 0;
`ifdef FASTRAM_FWD_EN
        foreach (wq[i]) if (wq[i].addr == a) begin hit = 1; m_rdata = wq[i].data; end
`endif
        if (!hit) begin
          m_rd_pend = 1; m_rd_addr = a; m_rd_exp = golden_get(a); nwait = 1;
          exp_tx.push_back('{we: 1'b0, addr: a, data: 8'h00});
        end
      end
      if (acc && we) begin
        if (wq.size() >= DEPTH && !wr_ack) begin m_hold = 1; nwait = 1; end
        wq.push_back('{addr: a, data: d});
        golden[a] = d;
        exp_tx.push_back('{we: 1'b1, addr: a, data: d});
      end
      if (wr_ack) begin
        wq.delete(0);
        if (old_hold) begin m_hold = 0; nwait = 0; end
      end
      if (rd_ack) begin m_rd_acked = 1; rv_on = 1; rv_wait = rv_delay; end
      if (rv && old_acked) begin
        m_rdata = m_rd_exp; nwait = 0; m_rd_pend = 0; m_rd_acked = 0;
      end
      m_wait = nwait;
    end

    @(posedge clk_sys);
    #1;
    cyc++;
    chk("cpu_wait", cpu_wait, m_wait);
    chk("cpu_rdata", cpu_rdata, m_rdata);
    if (rst) chk("rst_req", sdram_req, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 8'h00);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    step(0, 1, 1, 1, a, d);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(0, 1, 1, 0, a, 8'h00);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((wq.size() != 0 || m_rd_pend || m_wait) && n < budget) begin
      idle(1); n++;
    end
    if (n >= budget) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d cycles expected < %0d", n, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc, n;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, 8'h00);
    chk("rst_wait", cpu_wait, 0);
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_req0", sdram_req, 0);

    // single posted write, ack after 3 request cycles
    ack_delay = 3;
    wr(23'h012345, 8'hA5);
    chk("t1_nowait", cpu_wait, 0);
    idle(8);
    chk("t1_addr", last_addr, 23'h012345);
    chk("t1_wdata", last_wd, 8'hA5);
    chk("t1_req_done", sdram_req, 0);

    // five back-to-back writes overflow into the hold register
    ack_delay = 10; n_wr_acks = 0;
    for (int i = 0; i < 5; i++) wr(23'h000100 + 23'(i), 8'h10 + 8'(i));
    chk("t2_hold_wait", cpu_wait, 1);
    drain(200);
    chk("t2_acks", n_wr_acks, 5);

    // read-after-write ordering
    ack_delay = 2;
    wr(23'h000400, 8'h3C);
    rd(23'h000400);
    drain(100);
    chk("t3_rdata", cpu_rdata, 8'h3C);

    // minimum read latency, then data held across writes
    ack_delay = 0; rv_delay = 1;
    acc_cyc = cyc;
    rd(23'h7F0000);
    n = 0;
    while (cpu_wait && n < 20) begin idle(1); n++; end
    chk("t4_latency", cyc - acc_cyc, 4);
    wr(23'h000500, 8'h77);
    wr(23'h000501, 8'h78);
    drain(100);
    chk("t4_rdata_held", cpu_rdata, 8'h5A);

    // reset with posted writes and a pending read, then a late rvalid
    ack_delay = 1000;
    wr(23'h000200, 8'hC1);
    wr(23'h000201, 8'hC2);
    rd(23'h000300);
    idle(2);
    step(1, 0, 0, 0, '0, 8'h00);
    chk("t5_req", sdram_req, 0);
    chk("t5_wait", cpu_wait, 0);
    chk("t5_rdata", cpu_rdata, 8'h00);
    force_rv = 1; idle(2); force_rv = 0;
    chk("t5_late_rv", cpu_rdata, 8'h00);
    ack_delay = 0; rv_delay = 6;
    rd(23'h000300);
    idle(4);
    step(1, 0, 0, 0, '0, 8'h00);
    force_rv = 1; idle(2); force_rv = 0;
    chk("t5b_rdata", cpu_rdata, 8'h00);
    rv_delay = 1;

`ifdef FASTRAM_FWD_EN
    ack_delay = 1000;
    wr(23'h001000, 8'h11);
    wr(23'h001000, 8'h22);
    rd(23'h001000);
    chk("fwd_rdata", cpu_rdata, 8'h22);
    chk("fwd_wait", cpu_wait, 0);
    for (int i = 0; i < 3; i++) begin idle(1); chk("fwd_no_rd", sdram_we, 1); end
    ack_delay = 0;
    drain(100);
`endif

    // randomized traffic with random ack/rvalid timing, strays and resets
    rand_ack = 1; stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      rv_delay = $urandom_range(1, 3);
      step(($urandom % 400) == 0, ($urandom % 3) != 0, ($urandom % 8) != 0,
           1'($urandom), 23'((($urandom % 4) << 16) | ($urandom % 8)), 8'($urandom));
    end
    stray_en = 0;
    drain(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
